// File: rtl/dmem_access_ctrl.sv
// Round-robin two-port front end for datamemory: word-only memory accesses,
// sub-word load extraction with sign/zero extension, and SB/SH as read-modify-write.
module dmem_access_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic [2:0]            p0_funct3,
    output logic                  p0_gnt,
    output logic                  p0_done,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic [2:0]            p1_funct3,
    output logic                  p1_gnt,
    output logic                  p1_done,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_err,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_rr;
    logic                  r_port;
    logic                  r_we;
    logic                  r_err;
    logic                  r_gnt;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_word;
    logic [2:0]            r_funct3;
    logic [DATA_W-1:0]     r_rdata0;
    logic [DATA_W-1:0]     r_rdata1;

    logic                  w_any;
    logic                  w_both;
    logic                  w_sel;
    logic                  w_selWe;
    logic [DM_ADDRESS-1:0] w_selAddr;
    logic [2:0]            w_selFunct3;
    logic                  w_selErr;
    logic                  w_accept;
    logic                  w_resp;
    logic [DATA_W-1:0]     w_loadVal;

    // Misalignment and illegal funct3 are rejected before any memory access.
    function automatic logic isIllegal(input logic [2:0] f3, input logic we, input logic [1:0] lane);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lane[0];
            3'b010:  bad = (lane != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | lane[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [DATA_W-1:0] extractLoad(input logic [2:0] f3, input logic [1:0] lane,
                                                      input logic [DATA_W-1:0] word);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{(DATA_W-8){b[7]}}, b};
            3'b100:  res = {{(DATA_W-8){1'b0}}, b};
            3'b001:  res = {{(DATA_W-16){h[15]}}, h};
            3'b101:  res = {{(DATA_W-16){1'b0}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] mergeStore(input logic [2:0] f3, input logic [1:0] lane,
                                                     input logic [DATA_W-1:0] word, input logic [15:0] wd);
        logic [DATA_W-1:0] res;
        res = word;
        if (f3 == 3'b001) begin
            if (lane[1]) res[31:16] = wd;
            else         res[15:0]  = wd;
        end else begin
            res[{lane, 3'b000} +: 8] = wd[7:0];
        end
        return res;
    endfunction

    // With a single requester it wins outright; a tie goes to the round-robin pointer.
    assign w_any       = p0_req | p1_req;
    assign w_both      = p0_req & p1_req;
    assign w_sel       = w_both ? r_rr : p1_req;
    assign w_selWe     = w_sel ? p1_we     : p0_we;
    assign w_selAddr   = w_sel ? p1_addr   : p0_addr;
    assign w_selFunct3 = w_sel ? p1_funct3 : p0_funct3;
    assign w_selErr    = isIllegal(w_selFunct3, w_selWe, w_selAddr[1:0]);
    assign w_accept    = (r_state == S_IDLE) && w_any;
    assign w_loadVal   = extractLoad(r_funct3, r_addr[1:0], mem_rd);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_selErr)                    w_next = S_RESP;
                    else if (!w_selWe)               w_next = S_RD;
                    else if (w_selFunct3 == 3'b010)  w_next = S_WR;
                    else                             w_next = S_RMW_RD;
                end
            end
            S_RD:     w_next = S_RESP;
            S_WR:     w_next = S_RESP;
            S_RMW_RD: w_next = S_RMW_WR;
            S_RMW_WR: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr     <= 1'b0;
            r_port   <= 1'b0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_gnt    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_funct3 <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state <= w_next;
            r_gnt   <= w_accept;
            if (w_accept) begin
                r_port   <= w_sel;
                r_we     <= w_selWe;
                r_err    <= w_selErr;
                r_addr   <= w_selAddr;
                r_wdata  <= w_sel ? p1_wdata : p0_wdata;
                r_funct3 <= w_selFunct3;
                if (w_both) r_rr <= ~r_rr;
            end
            if (r_state == S_RMW_RD) r_word <= mem_rd;
            if (r_state == S_RD && !r_we) begin
                if (r_port) r_rdata1 <= w_loadVal;
                else        r_rdata0 <= w_loadVal;
            end
        end
    end

    assign w_resp     = (r_state == S_RESP);
    assign p0_gnt     = r_gnt & ~r_port;
    assign p1_gnt     = r_gnt &  r_port;
    assign p0_done    = w_resp & ~r_port;
    assign p1_done    = w_resp &  r_port;
    assign p0_err     = p0_done & r_err;
    assign p1_err     = p1_done & r_err;
    assign p0_rdata   = r_rdata0;
    assign p1_rdata   = r_rdata1;

    // Memory strobes decode straight from state so an async reset drops them at once.
    assign mem_read   = (r_state == S_RD) || (r_state == S_RMW_RD);
    assign mem_write  = (r_state == S_WR) || (r_state == S_RMW_WR);
    assign mem_a      = (mem_read || mem_write) ? {r_addr[DM_ADDRESS-1:2], 2'b00} : '0;
    assign mem_wd     = (r_state == S_WR)     ? r_wdata :
                        (r_state == S_RMW_WR) ? mergeStore(r_funct3, r_addr[1:0], r_word, r_wdata[15:0]) :
                        '0;
    assign mem_funct3 = 3'b010;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural word-wide datamemory model.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [8:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [2:0]  p0_funct3, p1_funct3;
    logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd, mem_rd;
    logic [2:0]  mem_funct3;

    logic [31:0] memArr [0:127];
    logic        preEn;
    logic [6:0]  preIdx;
    logic [31:0] preData;

    int errors = 0;
    int checks = 0;

    dmem_access_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_funct3(p0_funct3),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_funct3(p1_funct3),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = memArr[mem_a[8:2]];
    always @(posedge clk) begin
        if (mem_write)  memArr[mem_a[8:2]] <= mem_wd;
        else if (preEn) memArr[preIdx]     <= preData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] val);
        preIdx  = idx;
        preData = val;
        preEn   = 1'b1;
        @(negedge clk);
        preEn   = 1'b0;
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [8:0] addr,
                                 input logic [31:0] wd, input logic [2:0] f3);
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_funct3 = f3; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_funct3 = f3; p1_req = 1'b1;
        end
    endtask

    // k counts falling edges after the request was raised in IDLE; done must land on expK.
    task automatic waitDone(input int port, input int expK, input string tag,
                            output logic [31:0] rd, output logic er, output logic sawMem);
        int   k;
        int   gntK;
        logic d;
        k = 0; gntK = 0; sawMem = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (mem_read || mem_write) sawMem = 1'b1;
            if ((port == 0 ? p0_gnt : p1_gnt) && gntK == 0) gntK = k;
            d = (port == 0) ? p0_done : p1_done;
        end while (!d && k < 10);
        checkOutput({tag, "_lat"}, k, expK);
        checkOutput({tag, "_gnt"}, gntK, 1);
        rd = (port == 0) ? p0_rdata : p1_rdata;
        er = (port == 0) ? p0_err   : p1_err;
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    logic        sawMem;

    initial begin
        logic [3:0]  orderBits;
        int          nGnt, bothG, bothD;
        logic [2:0]  t2F3   [4];
        logic [8:0]  t2Addr [4];
        logic [31:0] t2Exp  [4];
        int          ePort  [4];
        logic        eWe    [4];
        logic [8:0]  eAddr  [4];
        logic [2:0]  eF3    [4];

        rst_n = 1'b0; preEn = 1'b0; preIdx = '0; preData = '0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_funct3 = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_funct3 = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_funct3", mem_funct3, 3'b010);
        checkOutput("rst_strobes", {mem_read, mem_write, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err}, 8'h00);
        checkOutput("rst_mem_a", mem_a, 9'h000);
        checkOutput("rst_rdata", p0_rdata | p1_rdata | mem_wd, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        preload(7'd4,  32'hDEADBEEF);
        preload(7'd8,  32'h11223344);
        preload(7'd16, 32'h01020304);

        // T4: both ports load continuously; grants at edges 1,4,7,10 alternating from port 0.
        applyStimulus(0, 1'b0, 9'h010, 32'h0, 3'b010);
        applyStimulus(1, 1'b0, 9'h020, 32'h0, 3'b010);
        orderBits = '0; nGnt = 0; bothG = 0; bothD = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (p0_gnt && p1_gnt) bothG++;
            if (p0_done && p1_done) bothD++;
            if (p0_gnt) begin orderBits = {orderBits[2:0], 1'b0}; nGnt++; end
            if (p1_gnt) begin orderBits = {orderBits[2:0], 1'b1}; nGnt++; end
            if (p0_done) checkOutput("t4_p0_rdata", p0_rdata, 32'hDEADBEEF);
            if (p1_done) checkOutput("t4_p1_rdata", p1_rdata, 32'h11223344);
            if (k == 11) begin p0_req = 1'b0; p1_req = 1'b0; end
        end
        checkOutput("t4_ngnt", nGnt, 4);
        checkOutput("t4_order", orderBits, 4'b0101);
        checkOutput("t4_overlap", bothG + bothD, 0);
        @(negedge clk);

        // T1: word load, stepped cycle by cycle.
        applyStimulus(0, 1'b0, 9'h010, 32'h0, 3'b010);
        @(negedge clk);
        checkOutput("t1_c1_gnt", p0_gnt, 1'b1);
        checkOutput("t1_c1_rdwr", {mem_read, mem_write, p0_done}, 3'b100);
        checkOutput("t1_c1_mem_a", mem_a, 9'h010);
        @(negedge clk);
        checkOutput("t1_c2_done", {p0_done, p0_err, p0_gnt, mem_read}, 4'b1000);
        checkOutput("t1_c2_rdata", p0_rdata, 32'hDEADBEEF);
        p0_req = 1'b0;
        @(negedge clk);

        // T2: sub-word loads from one word.
        preload(7'd4, 32'h80FF1234);
        t2F3[0] = 3'b000; t2Addr[0] = 9'h013; t2Exp[0] = 32'hFFFFFF80;
        t2F3[1] = 3'b100; t2Addr[1] = 9'h013; t2Exp[1] = 32'h00000080;
        t2F3[2] = 3'b001; t2Addr[2] = 9'h012; t2Exp[2] = 32'hFFFF80FF;
        t2F3[3] = 3'b101; t2Addr[3] = 9'h010; t2Exp[3] = 32'h00001234;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b0, t2Addr[i], 32'h0, t2F3[i]);
            waitDone(0, 2, $sformatf("t2_%0d", i), rd, er, sawMem);
            checkOutput($sformatf("t2_%0d_rdata", i), rd, t2Exp[i]);
            checkOutput($sformatf("t2_%0d_err", i), er, 1'b0);
        end

        // T3: SB read-modify-write on port 1.
        applyStimulus(1, 1'b1, 9'h021, 32'hFFFFFFAB, 3'b000);
        @(negedge clk);
        checkOutput("t3_c1", {p1_gnt, mem_read, mem_write}, 3'b110);
        checkOutput("t3_c1_mem_a", mem_a, 9'h020);
        @(negedge clk);
        checkOutput("t3_c2", {mem_read, mem_write, p1_done}, 3'b010);
        checkOutput("t3_c2_wd", mem_wd, 32'h1122AB44);
        @(negedge clk);
        checkOutput("t3_c3_done", {p1_done, p1_err}, 2'b10);
        p1_req = 1'b0;
        @(negedge clk);
        checkOutput("t3_mem", memArr[8], 32'h1122AB44);

        applyStimulus(1, 1'b1, 9'h022, 32'h12345566, 3'b001);
        waitDone(1, 3, "sh", rd, er, sawMem);
        checkOutput("sh_mem", memArr[8], 32'h5566AB44);

        applyStimulus(0, 1'b1, 9'h030, 32'hCAFEF00D, 3'b010);
        waitDone(0, 2, "sw", rd, er, sawMem);
        checkOutput("sw_mem", memArr[12], 32'hCAFEF00D);
        checkOutput("sw_rdata_kept", rd, 32'h00001234);

        applyStimulus(1, 1'b0, 9'h020, 32'h0, 3'b010);
        waitDone(1, 2, "lw_back", rd, er, sawMem);
        checkOutput("lw_back_rdata", rd, 32'h5566AB44);

        // T5: rejected requests finish on the grant cycle without touching memory.
        applyStimulus(0, 1'b0, 9'h006, 32'h0, 3'b010);
        @(negedge clk);
        checkOutput("t5_lw", {p0_gnt, p0_done, p0_err, mem_read, mem_write}, 5'b11100);
        checkOutput("t5_lw_rdata", p0_rdata, 32'h00001234);
        p0_req = 1'b0;
        @(negedge clk);
        ePort[0] = 1; eWe[0] = 1'b1; eAddr[0] = 9'h011; eF3[0] = 3'b001;
        ePort[1] = 0; eWe[1] = 1'b1; eAddr[1] = 9'h010; eF3[1] = 3'b100;
        ePort[2] = 1; eWe[2] = 1'b0; eAddr[2] = 9'h020; eF3[2] = 3'b011;
        ePort[3] = 0; eWe[3] = 1'b0; eAddr[3] = 9'h013; eF3[3] = 3'b001;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ePort[i], eWe[i], eAddr[i], 32'h0, eF3[i]);
            waitDone(ePort[i], 1, $sformatf("t5_%0d", i), rd, er, sawMem);
            checkOutput($sformatf("t5_%0d_err", i), er, 1'b1);
            checkOutput($sformatf("t5_%0d_nomem", i), sawMem, 1'b0);
            checkOutput($sformatf("t5_%0d_rdata", i), rd, (ePort[i] == 0) ? 32'h00001234 : 32'h5566AB44);
        end
        checkOutput("t5_mem8", memArr[8], 32'h5566AB44);

        // T6: reset lands mid RMW_RD of an SH.
        applyStimulus(0, 1'b1, 9'h042, 32'h00009999, 3'b001);
        @(negedge clk);
        checkOutput("t6_rmw_rd", {mem_read, mem_write}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async", {mem_read, mem_write, p0_gnt, p0_done}, 4'b0000);
        checkOutput("t6_mem_a", mem_a, 9'h000);
        p0_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t6_mem", memArr[16], 32'h01020304);
        checkOutput("t6_rdata_clr", p0_rdata, 32'h0);
        applyStimulus(0, 1'b0, 9'h040, 32'h0, 3'b010);
        waitDone(0, 2, "t6_lw", rd, er, sawMem);
        checkOutput("t6_lw_rdata", rd, 32'h01020304);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
